// File: rtl/bus_sram_slave.sv
// Word-organised SRAM behind a simple request/ack bus with byte-lane writes,
// programmable wait states and an out-of-range error flag.
module bus_sram_slave #(
    parameter int          DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 1,
    parameter string       INIT_FILE   = ""
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_bus_en,
    input  logic        i_wr_en,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wr_data,
    input  logic [3:0]  i_byte_en,
    output logic        o_ack,
    output logic [31:0] o_rd_data,
    output logic        o_err,
    output logic [1:0]  o_dbg_state
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_ACK     = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t state, state_nxt;
    logic [3:0] wait_cnt, wait_cnt_nxt;

    logic [31:0] mem [DEPTH_WORDS];

    // Handshake: i_bus_en is held by the master until it sees the single-cycle
    // o_ack; the slave then waits for i_bus_en to drop before taking a new request.
    logic          cap_wr;
    logic          cap_ok;
    logic [AW-1:0] cap_idx;
    logic [31:0]   cap_data;
    logic [3:0]    cap_be;

    logic [31:0]   byte_off;
    logic [29:0]   word_off;
    logic          req_ok;
    logic [AW-1:0] req_idx;
    logic          unused_bits;

    assign byte_off    = i_addr - BASE_ADDR;
    assign word_off    = byte_off[31:2];
    assign req_ok      = {2'b00, word_off} < 32'(DEPTH_WORDS);
    assign req_idx     = word_off[AW-1:0];
    assign unused_bits = ^byte_off[1:0];

    // With zero wait states ACK is entered straight from IDLE, so the access
    // uses the live request; otherwise it uses the captured copy.
    logic          acc_wr;
    logic          acc_ok;
    logic [AW-1:0] acc_idx;
    logic [31:0]   acc_data;
    logic [3:0]    acc_be;
    logic          enter_ack;

    assign acc_wr    = (state == S_IDLE) ? i_wr_en   : cap_wr;
    assign acc_ok    = (state == S_IDLE) ? req_ok    : cap_ok;
    assign acc_idx   = (state == S_IDLE) ? req_idx   : cap_idx;
    assign acc_data  = (state == S_IDLE) ? i_wr_data : cap_data;
    assign acc_be    = (state == S_IDLE) ? i_byte_en : cap_be;
    assign enter_ack = (state_nxt == S_ACK);

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            S_IDLE: begin
                if (i_bus_en) begin
                    if (WAIT_STATES > 0) begin
                        state_nxt    = S_WAIT;
                        wait_cnt_nxt = WAIT_LOAD;
                    end else begin
                        state_nxt = S_ACK;
                    end
                end
            end
            S_WAIT: begin
                if (wait_cnt == 4'd0) state_nxt = S_ACK;
                else                  wait_cnt_nxt = wait_cnt - 4'd1;
            end
            S_ACK:     state_nxt = S_RELEASE;
            S_RELEASE: if (!i_bus_en) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state     <= S_IDLE;
            wait_cnt  <= 4'd0;
            o_rd_data <= 32'h0;
            cap_wr    <= 1'b0;
            cap_ok    <= 1'b0;
            cap_idx   <= '0;
            cap_data  <= 32'h0;
            cap_be    <= 4'h0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (state == S_IDLE && i_bus_en) begin
                cap_wr   <= i_wr_en;
                cap_ok   <= req_ok;
                cap_idx  <= req_idx;
                cap_data <= i_wr_data;
                cap_be   <= i_byte_en;
            end
            if (enter_ack && !acc_wr) o_rd_data <= acc_ok ? mem[acc_idx] : 32'h0;
        end
    end

    // Storage has no reset; the i_rst term keeps an aborted access from writing.
    always_ff @(posedge i_clk) begin
        if (i_rst && enter_ack && acc_wr && acc_ok) begin
            for (int k = 0; k < 4; k++) begin
                if (acc_be[k]) mem[acc_idx][8*k +: 8] <= acc_data[8*k +: 8];
            end
        end
    end

    assign o_ack       = (state == S_ACK);
    assign o_err       = (state == S_ACK) && !cap_ok;
    assign o_dbg_state = state;

endmodule

// File: tb/tb_bus_sram_slave.sv
// Directed plus randomized bench for bus_sram_slave: three instances cover
// one, three and zero wait states, with a word-map reference model.
module tb_bus_sram_slave;

    localparam int          WS_P    [3] = '{1, 3, 0};
    localparam int          DEPTH_P [3] = '{4096, 4096, 256};
    localparam logic [31:0] BASE_P  [3] = '{32'h0, 32'h0, 32'h1000};

    logic        clk;
    logic        rst_n;
    logic        bus_en [3];
    logic        wr_en  [3];
    logic [31:0] addr   [3];
    logic [31:0] wdata  [3];
    logic [3:0]  be     [3];
    logic        ack    [3];
    logic [31:0] rdata  [3];
    logic        err    [3];
    logic [1:0]  dbg    [3];

    int          n_cmp;
    int          n_bad;
    bit   [31:0] mdl [int];
    logic [31:0] exp_q [$];
    logic [31:0] last_rd    [3];
    bit          last_rd_ok [3];
    logic [31:0] pool [3][6];

    bus_sram_slave #(.DEPTH_WORDS(DEPTH_P[0]), .BASE_ADDR(BASE_P[0]), .WAIT_STATES(WS_P[0]), .INIT_FILE("")) u_ws1 (
        .i_clk(clk), .i_rst(rst_n), .i_bus_en(bus_en[0]), .i_wr_en(wr_en[0]), .i_addr(addr[0]),
        .i_wr_data(wdata[0]), .i_byte_en(be[0]), .o_ack(ack[0]), .o_rd_data(rdata[0]), .o_err(err[0]),
        .o_dbg_state(dbg[0]));

    bus_sram_slave #(.DEPTH_WORDS(DEPTH_P[1]), .BASE_ADDR(BASE_P[1]), .WAIT_STATES(WS_P[1]), .INIT_FILE("")) u_ws3 (
        .i_clk(clk), .i_rst(rst_n), .i_bus_en(bus_en[1]), .i_wr_en(wr_en[1]), .i_addr(addr[1]),
        .i_wr_data(wdata[1]), .i_byte_en(be[1]), .o_ack(ack[1]), .o_rd_data(rdata[1]), .o_err(err[1]),
        .o_dbg_state(dbg[1]));

    bus_sram_slave #(.DEPTH_WORDS(DEPTH_P[2]), .BASE_ADDR(BASE_P[2]), .WAIT_STATES(WS_P[2]), .INIT_FILE("")) u_ws0 (
        .i_clk(clk), .i_rst(rst_n), .i_bus_en(bus_en[2]), .i_wr_en(wr_en[2]), .i_addr(addr[2]),
        .i_wr_data(wdata[2]), .i_byte_en(be[2]), .o_ack(ack[2]), .o_rd_data(rdata[2]), .o_err(err[2]),
        .o_dbg_state(dbg[2]));

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic bit in_rng(input int d, input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_P[d];
        return (off >> 2) < 32'(DEPTH_P[d]);
    endfunction

    function automatic int mkey(input int d, input logic [31:0] a);
        logic [31:0] off;
        off = (a - BASE_P[d]) >> 2;
        return d * 65536 + int'(off[15:0]);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- driver + scoreboard ----------------
    task automatic op(input int d, input logic wr, input logic [31:0] a, input logic [31:0] data,
                      input logic [3:0] lanes, input int hold, input string tag);
        logic        got;
        logic [31:0] rd;
        logic        e;
        int          lat;
        int          extra;
        bit          ok;
        bit          known;
        int          k;
        ok    = in_rng(d, a);
        k     = mkey(d, a);
        known = ok && mdl.exists(k);
        if (!wr && !ok)   exp_q.push_back(32'h0);
        if (!wr && known) exp_q.push_back(mdl[k]);

        bus_en[d] = 1'b1; wr_en[d] = wr; addr[d] = a; wdata[d] = data; be[d] = lanes;
        got = 1'b0; lat = 0; rd = 32'h0; e = 1'b0; extra = 0;
        for (int c = 1; c <= 40 && !got; c++) begin
            @(posedge clk); #1;
            if (ack[d]) begin
                got = 1'b1; lat = c; rd = rdata[d]; e = err[d];
            end else if (c == 1) begin
                wr_en[d] = 1'($urandom); addr[d] = $urandom; wdata[d] = $urandom; be[d] = 4'($urandom);
            end
        end
        check({tag, ".ack_seen"}, {31'b0, got}, 32'd1);
        repeat (hold) begin
            @(posedge clk); #1;
            if (ack[d]) extra++;
        end
        bus_en[d] = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            if (ack[d]) extra++;
        end
        check({tag, ".latency"}, lat, WS_P[d] + 1);
        check({tag, ".err"}, {31'b0, e}, {31'b0, !ok});
        check({tag, ".extra_acks"}, extra, 0);

        if (wr) begin
            if (last_rd_ok[d]) check({tag, ".rd_hold"}, rdata[d], last_rd[d]);
            if (ok) begin
                if (!mdl.exists(k)) mdl[k] = 32'h0;
                for (int b = 0; b < 4; b++)
                    if (lanes[b]) mdl[k][8*b +: 8] = data[8*b +: 8];
            end
        end else if (!ok || known) begin
            last_rd[d]    = exp_q.pop_front();
            last_rd_ok[d] = 1'b1;
            check({tag, ".rd_data"}, rd, last_rd[d]);
        end else begin
            last_rd_ok[d] = 1'b0;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            bus_en[d] = 1'b0; wr_en[d] = 1'b0; addr[d] = 32'h0; wdata[d] = 32'h0; be[d] = 4'h0;
            last_rd[d] = 32'h0; last_rd_ok[d] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset.ack%0d", d), {31'b0, ack[d]}, 32'd0);
            check($sformatf("reset.err%0d", d), {31'b0, err[d]}, 32'd0);
            check($sformatf("reset.rd%0d", d), rdata[d], 32'h0);
        end

        // request already pending while reset releases
        bus_en[0] = 1'b1; wr_en[0] = 1'b0; addr[0] = 32'h10; be[0] = 4'h0;
        @(posedge clk); #1;
        check("in_reset.no_ack", {31'b0, ack[0]}, 32'd0);
        rst_n = 1'b1;
        op(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, "first_read");

        // byte-lane merge
        op(0, 1'b1, 32'h20, 32'hAABB_CCDD, 4'b1111, 0, "wr_full");
        op(0, 1'b1, 32'h20, 32'h1122_3344, 4'b0101, 0, "wr_lanes");
        op(0, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'b0000, 0, "wr_no_lanes");
        op(0, 1'b0, 32'h20, 32'h0, 4'b0000, 0, "rd_merge");
        check("rd_merge.const", last_rd[0], 32'hAA22_CC44);

        // out of range on both sides, storage at the aliased index untouched
        op(0, 1'b1, 32'h0, 32'h5A5A_0F0F, 4'b1111, 0, "wr_word0");
        op(0, 1'b0, 32'h4000, 32'h0, 4'b1111, 0, "rd_oor");
        op(0, 1'b1, 32'h4000, 32'hDEAD_BEEF, 4'b1111, 0, "wr_oor");
        op(0, 1'b0, 32'h0, 32'h0, 4'b0000, 0, "rd_word0");

        // held request produces one ack, re-request acks on schedule
        op(0, 1'b0, 32'h20, 32'h0, 4'h0, 6, "held_req");
        op(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, "re_req");

        // reset during wait states aborts the write
        op(1, 1'b1, 32'h8, 32'h1234_5678, 4'b1111, 0, "ws3_prior");
        bus_en[1] = 1'b1; wr_en[1] = 1'b1; addr[1] = 32'h8; wdata[1] = 32'hCAFE_F00D; be[1] = 4'b1111;
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("abort.pre_ack", {31'b0, ack[1]}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("abort.rd_cleared", rdata[0], 32'h0);
        bus_en[1] = 1'b0;
        begin
            int seen;
            seen = 0;
            repeat (4) begin
                @(posedge clk); #1;
                if (ack[1] || err[1]) seen++;
            end
            check("abort.no_ack", seen, 0);
        end
        rst_n = 1'b1;
        for (int d = 0; d < 3; d++) begin
            last_rd[d] = 32'h0; last_rd_ok[d] = 1'b1;
        end
        op(1, 1'b0, 32'h8, 32'h0, 4'h0, 0, "abort.rd_prior");

        // zero wait states, non-zero base
        op(2, 1'b1, 32'h1010, 32'h0BAD_F00D, 4'b1111, 0, "ws0_wr");
        op(2, 1'b0, 32'h1010, 32'h0, 4'h0, 0, "ws0_rd");
        op(2, 1'b1, 32'h13FC, 32'h7777_8888, 4'b1111, 0, "ws0_wr_top");
        op(2, 1'b0, 32'h13FC, 32'h0, 4'h0, 0, "ws0_rd_top");
        op(2, 1'b0, 32'h1400, 32'h0, 4'h0, 0, "ws0_rd_above");
        op(2, 1'b0, 32'h0FFC, 32'h0, 4'h0, 0, "ws0_rd_below");

        // randomized traffic over a prefilled address pool
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 6; i++) begin
                pool[d][i] = BASE_P[d] + 32'($urandom_range(0, DEPTH_P[d] - 1)) * 4 + 32'($urandom_range(0, 3));
                op(d, 1'b1, pool[d][i], $urandom, 4'b1111, 0, $sformatf("fill%0d_%0d", d, i));
            end
        end
        for (int n = 0; n < 45; n++) begin
            int          d;
            logic [31:0] a;
            d = $urandom_range(0, 2);
            if ($urandom_range(0, 4) != 0) a = pool[d][$urandom_range(0, 5)];
            else if ($urandom_range(0, 1) == 0)
                a = BASE_P[d] + 32'(DEPTH_P[d] + $urandom_range(0, 500)) * 4;
            else
                a = BASE_P[d] - 32'($urandom_range(1, 64)) * 4;
            op(d, 1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3), $sformatf("rnd%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: observed no completion, expected finish");
        $fatal(1, "timeout");
    end

endmodule
